// File: rtl/lane_word_aligner.sv
// ---------------------------------------------------------------------------
// lane_word_aligner
//
// Multi-lane word-boundary aligner. Every lane keeps its two most recent
// raw words and extracts a DW-bit window from them at a per-lane bit
// offset. A per-lane HUNT / VERIFY / LOCKED state machine moves the offset
// by one bit whenever the hunt timer expires without the downstream framer
// reporting a good boundary on iSync. Once the framer has been happy for
// LOCK_CNT consecutive cycles the offset freezes until LOSS_CNT consecutive
// bad cycles are seen.
//
// Ports
//   iSclk    in   1          clock, all logic on the rising edge
//   iRstN    in   1          asynchronous active-low reset
//   iD_Link  in   LANES*DW   raw lane words, lane l at [l*DW +: DW]
//   iSync    in   LANES      per-lane "boundary good" level from the framer
//   oD_Link  out  LANES*DW   aligned words, same packing as iD_Link
//   oSlip    out  LANES*SW   current bit offset per lane (0..DW-1)
//   oLock    out  LANES      per-lane lock status
//   oRst     out  LANES      one-cycle pulse after each offset change
//   oWrap    out  LANES      sticky: offset wrapped DW-1 -> 0 while hunting
// ---------------------------------------------------------------------------
module lane_word_aligner #(
  parameter int DW       = 20,
  parameter int LANES    = 4,
  parameter int TO_W     = 21,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int SW       = $clog2(DW)
) (
  input  logic                  iSclk,
  input  logic                  iRstN,
  input  logic [LANES*DW-1:0]   iD_Link,
  input  logic [LANES-1:0]      iSync,
  output logic [LANES*DW-1:0]   oD_Link,
  output logic [LANES*SW-1:0]   oSlip,
  output logic [LANES-1:0]      oLock,
  output logic [LANES-1:0]      oRst,
  output logic [LANES-1:0]      oWrap
);

  // Good/bad run counters share one width sized for the larger threshold.
  localparam int CMAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  // A zero-width timer is kept as one bit; it is then treated as always expired.
  localparam int TW   = (TO_W > 0) ? TO_W : 1;

  localparam logic [CW-1:0] LOCK_V  = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_V  = CW'(LOSS_CNT);
  localparam logic [SW-1:0] OFF_MAX = SW'(DW - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Saturating increment: a counter parks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane

    logic [DW-1:0]   cur_q, prev_q;
    logic [DW-1:0]   od_q, od_d;
    logic [2*DW-1:0] cat_shift;
    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   good_q, good_d;
    logic [CW-1:0]   bad_q, bad_d;
    logic [SW-1:0]   off_q, off_d;
    logic            lock_q, lock_d;
    logic            rst_q, rst_d;
    logic            wrap_q, wrap_d;
    logic            sync;
    logic            timer_full;

    assign sync       = iSync[l];
    assign timer_full = (TO_W == 0) ? 1'b1 : (&timer_q);

    // Window select: shifting {cur, prev} left by the offset puts
    // C[2DW-1-s : DW-s] in the top DW bits. The offset used is the one
    // registered before this edge, so a slip shows on the next output word.
    always_comb begin : p_window
      cat_shift = {cur_q, prev_q} << off_q;
      od_d      = cat_shift[2*DW-1 -: DW];
    end

    always_comb begin : p_fsm
      state_d = state_q;
      timer_d = '0;
      good_d  = good_q;
      bad_d   = bad_q;
      off_d   = off_q;
      wrap_d  = wrap_q;

      case (state_q)
        ST_HUNT: begin
          if (sync) begin
            // A good boundary beats a simultaneous timeout: no slip.
            state_d = ST_VERIFY;
            good_d  = CW'(1);
          end else if (timer_full) begin
            if (off_q == OFF_MAX) begin
              off_d  = '0;
              wrap_d = 1'b1;
            end else begin
              off_d  = off_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        ST_VERIFY: begin
          if (sync) begin
            good_d = sat_inc(good_q);
            if (good_d >= LOCK_V) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d = ST_HUNT;
            good_d  = '0;
          end
        end

        ST_LOCKED: begin
          if (sync) begin
            bad_d = '0;
          end else begin
            bad_d = sat_inc(bad_q);
            if (bad_d >= LOSS_V) begin
              // Offset is kept: re-hunting starts from the last good boundary.
              state_d = ST_HUNT;
              bad_d   = '0;
              good_d  = '0;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    // Status flags follow the next state / next offset so that they appear
    // in the cycle right after the corresponding transition.
    always_comb begin : p_status
      lock_d = (state_d == ST_LOCKED);
      rst_d  = (off_d != off_q);
    end

    always_ff @(posedge iSclk or negedge iRstN) begin : p_regs
      if (!iRstN) begin
        cur_q   <= '0;
        prev_q  <= '0;
        od_q    <= '0;
        state_q <= ST_HUNT;
        timer_q <= '0;
        good_q  <= '0;
        bad_q   <= '0;
        off_q   <= '0;
        lock_q  <= 1'b0;
        rst_q   <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        cur_q   <= iD_Link[l*DW +: DW];
        prev_q  <= cur_q;
        od_q    <= od_d;
        state_q <= state_d;
        timer_q <= timer_d;
        good_q  <= good_d;
        bad_q   <= bad_d;
        off_q   <= off_d;
        lock_q  <= lock_d;
        rst_q   <= rst_d;
        wrap_q  <= wrap_d;
      end
    end

    assign oD_Link[l*DW +: DW] = od_q;
    assign oSlip[l*SW +: SW]   = off_q;
    assign oLock[l]            = lock_q;
    assign oRst[l]             = rst_q;
    assign oWrap[l]            = wrap_q;

  end : g_lane

endmodule

// File: tb/tb_lane_word_aligner.sv
module tb_lane_word_aligner;

  localparam int DW       = 20;
  localparam int LANES    = 4;
  localparam int TO_W     = 4;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int SW       = $clog2(DW);
  localparam int TMAX     = (1 << TO_W) - 1;
  localparam int CW       = $clog2(((LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT) + 1);
  localparam int CSAT     = (1 << CW) - 1;

  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic                  clk = 1'b0;
  logic                  iRstN = 1'b1;
  logic [LANES*DW-1:0]   iD_Link = '0;
  logic [LANES-1:0]      iSync = '0;
  logic [LANES*DW-1:0]   oD_Link;
  logic [LANES*SW-1:0]   oSlip;
  logic [LANES-1:0]      oLock;
  logic [LANES-1:0]      oRst;
  logic [LANES-1:0]      oWrap;

  lane_word_aligner #(
    .DW(DW), .LANES(LANES), .TO_W(TO_W),
    .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .SW(SW)
  ) dut (
    .iSclk(clk), .iRstN(iRstN), .iD_Link(iD_Link), .iSync(iSync),
    .oD_Link(oD_Link), .oSlip(oSlip), .oLock(oLock), .oRst(oRst), .oWrap(oWrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard and reference model ----------------
  typedef struct packed {
    logic [LANES*DW-1:0] od;
    logic [LANES*SW-1:0] slip;
    logic [LANES-1:0]    lock;
    logic [LANES-1:0]    rst;
    logic [LANES-1:0]    wrap;
  } exp_t;

  exp_t sb_q[$];

  int            m_state[LANES];
  int            m_timer[LANES];
  int            m_off[LANES];
  int            m_good[LANES];
  int            m_bad[LANES];
  logic [DW-1:0] m_cur[LANES];
  logic [DW-1:0] m_prev[LANES];
  logic [DW-1:0] m_od[LANES];
  bit            m_lock[LANES];
  bit            m_rst[LANES];
  bit            m_wrap[LANES];

  function automatic logic [DW-1:0] extract(input logic [DW-1:0] c, input logic [DW-1:0] p, input int s);
    logic [DW-1:0] r;
    int idx;
    for (int b = 0; b < DW; b++) begin
      idx  = DW - s + b;
      r[b] = (idx >= DW) ? c[idx-DW] : p[idx];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_state[l] = M_HUNT; m_timer[l] = 0; m_off[l] = 0;
      m_good[l] = 0; m_bad[l] = 0;
      m_cur[l] = '0; m_prev[l] = '0; m_od[l] = '0;
      m_lock[l] = 0; m_rst[l] = 0; m_wrap[l] = 0;
    end
  endtask

  task automatic model_step(input logic [LANES-1:0] sync, input logic [LANES*DW-1:0] data);
    exp_t e;
    int old_off;
    for (int l = 0; l < LANES; l++) begin
      old_off   = m_off[l];
      m_od[l]   = extract(m_cur[l], m_prev[l], m_off[l]);
      m_prev[l] = m_cur[l];
      m_cur[l]  = data[l*DW +: DW];
      if (m_state[l] == M_HUNT) begin
        if (sync[l]) begin
          m_state[l] = M_VERIFY; m_good[l] = 1; m_timer[l] = 0;
        end else if (m_timer[l] == TMAX) begin
          m_timer[l] = 0;
          if (m_off[l] == DW - 1) begin m_off[l] = 0; m_wrap[l] = 1; end
          else m_off[l] = m_off[l] + 1;
        end else begin
          m_timer[l] = m_timer[l] + 1;
        end
      end else if (m_state[l] == M_VERIFY) begin
        if (sync[l]) begin
          m_good[l] = (m_good[l] < CSAT) ? m_good[l] + 1 : CSAT;
          if (m_good[l] >= LOCK_CNT) begin m_state[l] = M_LOCKED; m_bad[l] = 0; end
        end else begin
          m_state[l] = M_HUNT; m_good[l] = 0; m_timer[l] = 0;
        end
      end else begin
        if (sync[l]) m_bad[l] = 0;
        else begin
          m_bad[l] = (m_bad[l] < CSAT) ? m_bad[l] + 1 : CSAT;
          if (m_bad[l] >= LOSS_CNT) begin
            m_state[l] = M_HUNT; m_bad[l] = 0; m_good[l] = 0; m_timer[l] = 0;
          end
        end
      end
      m_lock[l] = (m_state[l] == M_LOCKED);
      m_rst[l]  = (m_off[l] != old_off);
      e.od[l*DW +: DW]   = m_od[l];
      e.slip[l*SW +: SW] = SW'(m_off[l]);
      e.lock[l]          = m_lock[l];
      e.rst[l]           = m_rst[l];
      e.wrap[l]          = m_wrap[l];
    end
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic drive_cycle(input logic [LANES-1:0] sync, input logic [LANES*DW-1:0] data);
    exp_t e;
    iSync   = sync;
    iD_Link = data;
    model_step(sync, data);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 128'd0, 128'd1);
    end else begin
      e = sb_q.pop_front();
      check("od_link", oD_Link, e.od);
      check("slip",    oSlip,   e.slip);
      check("lock",    oLock,   e.lock);
      check("rst",     oRst,    e.rst);
      check("wrap",    oWrap,   e.wrap);
    end
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    #1;
    check("rst_od",   oD_Link, '0);
    check("rst_slip", oSlip,   '0);
    check("rst_lock", oLock,   '0);
    check("rst_rst",  oRst,    '0);
    check("rst_wrap", oWrap,   '0);
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #2;
    iRstN = 1'b1;
  endtask

  function automatic logic [LANES*DW-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[LANES*DW-1:0];
  endfunction

  function automatic logic [SW-1:0] slip_of(input int l);
    return oSlip[l*SW +: SW];
  endfunction

  function automatic logic [DW-1:0] od_of(input int l);
    return oD_Link[l*DW +: DW];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LANES*DW-1:0] d;
    logic [DW-1:0] w1, w2, exp_w;

    model_reset();
    #2;
    do_reset();

    // Slip cadence and wrap, all lanes hunting.
    for (int k = 1; k <= 20 * 16; k++) begin
      drive_cycle(4'b0000, rand_data());
      if (k == 15) check("cad_slip15", slip_of(0), 5'd0);
      if (k == 16) begin
        check("cad_slip16", slip_of(0), 5'd1);
        check("cad_rst16", oRst[0], 1'b1);
      end
      if (k == 17) check("cad_rst17", oRst[0], 1'b0);
      if (k == 319) begin
        check("cad_slip319", slip_of(0), 5'd19);
        check("cad_wrap319", oWrap[0], 1'b0);
      end
      if (k == 320) begin
        check("cad_slip_all", oSlip, '0);
        check("cad_wrap_all", oWrap, 4'hF);
      end
    end

    // Data path at offset 3.
    for (int k = 1; k <= 48; k++) drive_cycle(4'b0000, '0);
    check("dp_slip3", slip_of(0), 5'd3);
    d = rand_data(); d[DW-1:0] = 20'hABCDE;
    drive_cycle(4'b0000, d);
    d = rand_data(); d[DW-1:0] = 20'h12345;
    drive_cycle(4'b0000, d);
    drive_cycle(4'b0000, rand_data());
    check("dp_word", od_of(0), 20'h91A2D);

    // Lock, hold through short dropouts, then loss of lock.
    do_reset();
    for (int k = 1; k <= 48; k++) drive_cycle(4'b0000, rand_data());
    for (int k = 1; k <= 4; k++) begin
      drive_cycle(4'b0001, rand_data());
      if (k == 3) check("lk_notyet", oLock[0], 1'b0);
    end
    check("lk_locked", oLock[0], 1'b1);
    for (int k = 1; k <= 20; k++) drive_cycle(4'b0001, rand_data());
    check("lk_frozen", slip_of(0), 5'd3);
    begin
      logic [5:0] pat;
      pat = 6'b100100;  // applied LSB first: L,L,H,L,L,H
      for (int k = 0; k < 6; k++) begin
        drive_cycle({3'b000, pat[k]}, rand_data());
        check("lk_hold", oLock[0], 1'b1);
      end
    end
    drive_cycle(4'b0000, rand_data());
    drive_cycle(4'b0000, rand_data());
    check("lk_hold2", oLock[0], 1'b1);
    drive_cycle(4'b0000, rand_data());
    check("lk_lost", oLock[0], 1'b0);
    check("lk_lost_slip", slip_of(0), 5'd3);

    // Sync arriving on timeout, then VERIFY abort.
    do_reset();
    for (int k = 1; k <= 15; k++) drive_cycle(4'b0000, rand_data());
    drive_cycle(4'b0001, rand_data());
    check("sim_noslip", slip_of(0), 5'd0);
    check("sim_norst", oRst[0], 1'b0);
    check("sim_l1slip", slip_of(1), 5'd1);
    drive_cycle(4'b0001, rand_data());
    drive_cycle(4'b0000, rand_data());
    for (int k = 19; k <= 33; k++) drive_cycle(4'b0000, rand_data());
    check("ab_slip33", slip_of(0), 5'd0);
    drive_cycle(4'b0000, rand_data());
    check("ab_slip34", slip_of(0), 5'd1);
    check("ab_rst34", oRst[0], 1'b1);

    // Reset while lane 2 is locked at offset 7 with wrap set.
    do_reset();
    for (int k = 1; k <= 27 * 16; k++) drive_cycle(4'b0000, rand_data());
    for (int k = 1; k <= 4; k++) drive_cycle(4'b0100, rand_data());
    check("mr_slip7", slip_of(2), 5'd7);
    check("mr_wrap", oWrap[2], 1'b1);
    check("mr_lock", oLock[2], 1'b1);
    do_reset();
    for (int k = 1; k <= 15; k++) drive_cycle(4'b0000, rand_data());
    check("mr_reh15", slip_of(2), 5'd0);
    check("mr_wrap0", oWrap[2], 1'b0);
    drive_cycle(4'b0000, rand_data());
    check("mr_reh16", slip_of(2), 5'd1);

    // Lane 1 locked while lane 3 keeps hunting.
    do_reset();
    for (int k = 1; k <= 32; k++) drive_cycle(4'b0000, rand_data());
    for (int k = 1; k <= 4; k++) drive_cycle(4'b0010, rand_data());
    w1 = 20'h0F0F0;
    w2 = 20'h33CC3;
    for (int k = 1; k <= 41; k++) begin
      d = rand_data();
      if (k == 39) d[1*DW +: DW] = w1;
      if (k == 40) d[1*DW +: DW] = w2;
      drive_cycle(4'b0010, d);
    end
    exp_w = {w2[17:0], w1[19:18]};
    check("ind_od1", od_of(1), exp_w);
    check("ind_slip1", slip_of(1), 5'd2);
    check("ind_lock1", oLock[1], 1'b1);
    check("ind_slip3", slip_of(3), 5'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
